apb_mcu_maint_regs: RTL and testbench
=====================================

// Module: apb_mcu_maint_regs
// PURPOSE
//  Parametrised APB3 slave that exposes the maintenance-device (MCU2IPU) status
//  to the APB bus: N-core running/online status, sticky fault/NMI flags and an
//  interrupt-event FIFO.
//  Sits between the APB bridge and the MCU maintenance port.
//  The MCU2IPU inputs are already synchronised to PCLK upstream, so the block
//  runs on a single clock.
//  Drives one level IRQ towards the interrupt controller.
// PARAMETERS
//  NUM_CORES   4   cores reported, 1..16
//  INT_INFO_W  4   MCU2IPU_IntInfo width, 1..16
//  FIFO_DEPTH  8   interrupt FIFO entries, power of 2, >=2
//  ADDR_W      16  PADDR width
// PORTS
//  PCLK                 in   1           APB clock; the only clock
//  PRESET               in   1           synchronous active-high reset
//  PSEL                 in   1           APB select
//  PENABLE              in   1           APB access phase
//  PWRITE               in   1           1=write, 0=read
//  PADDR                in   ADDR_W      byte address; bits [4:2] decoded
//  PWDATA               in   32          write data
//  PRDATA               out  32          read data, registered
//  PREADY               out  1           constant 1 (zero wait states)
//  MCU2IPU_CoreRunning  in   NUM_CORES   per-core running, level
//  MCU2IPU_CoreOnline   in   NUM_CORES   per-core online, level
//  MCU2IPU_FaultInt     in   1           fault interrupt, level
//  MCU2IPU_NMI          in   1           NMI, level
//  MCU2IPU_IntValid     in   1           1-cycle strobe, qualifies IntInfo
//  MCU2IPU_IntInfo      in   INT_INFO_W  interrupt info
//  IRQ                  out  1           registered interrupt request
// BEHAVIOUR
//  Phases
//   - setup = PSEL & ~PENABLE; access = PSEL & PENABLE.
//   - Register writes and FIFO pops occur only in the access phase.
//  Reset (PRESET=1 at a PCLK edge)
//   - PRDATA=0, IRQ=0, sticky flags=0, IRQ_EN=0.
//   - FIFO flushed: pointers=0, count=0.
//   - Applies mid-transfer: any in-flight pop or write is abandoned.
//  Reads
//   - PRDATA is loaded on the setup-phase edge of a read.
//   - PRDATA is valid throughout the access phase; 1-cycle latency.
//   - PRDATA holds its value otherwise.
//   - Unmapped or unused bits read 0.
//  Register map
//   - 0x00 STATUS RO: [NUM_CORES-1:0]=CoreRunning; [16+NUM_CORES-1:16]=CoreOnline.
//   - 0x04 FLAGS W1C: [0]=fault; [1]=NMI; [2]=FIFO overflow.
//   - 0x08 INTPOP RO: [31]=valid, i.e. FIFO not empty at the setup edge;
//     [INT_INFO_W-1:0]=head entry.
//     Access phase with valid=1 pops one entry.
//     Empty FIFO reads 0 and does not pop.
//   - 0x0C FIFOCNT RO: [$clog2(FIFO_DEPTH):0]=occupancy 0..FIFO_DEPTH.
//   - 0x10 IRQ_EN RW: [3:0] = {fifo_nonempty, ovf, nmi, fault} enables.
//   - Writes to RO or unmapped registers are ignored.
//  Sticky flags
//   - fault/NMI: set every cycle their input is 1.
//   - A W1C clear and a set in the same cycle: set wins.
//  Interrupt FIFO
//   - IntValid=1 and not full: push IntInfo.
//   - IntValid=1 and full: entry dropped, ovf flag set.
//   - Push and pop in the same cycle when full: push accepted, count unchanged,
//     ovf not set.
//   - Push and pop in the same cycle when empty: push accepted, no pop.
//   - Pointers wrap modulo FIFO_DEPTH; count saturates at 0 and FIFO_DEPTH.
//  IRQ
//   - IRQ <= |(IRQ_EN[2:0] & flags) | (IRQ_EN[3] & count!=0).
//   - Registered: IRQ follows its cause one cycle later.
// CONFIGURATION
//  APB_MCU_PSLVERR_EN
//   - Defined: adds output PSLVERR (1 bit). PSLVERR=1 in the access phase of
//     (a) a write to a RO register, (b) any access to an unmapped address,
//     (c) a read of INTPOP when empty. It is 0 otherwise and 0 in reset.
//   - Undefined: no PSLVERR port; the error cases above complete silently.
// TESTING
//  1. Pulse PRESET mid-read of INTPOP with 3 entries queued
//     -> PRDATA=0, FIFOCNT=0, IRQ=0, FLAGS=0.
//  2. CoreRunning=4'b1010, CoreOnline=4'b1111, read 0x00 -> PRDATA=0x000F_000A.
//  3. Push IntInfo 1,2,3, then read 0x08 three times -> 0x8000_0001,
//     0x8000_0002, 0x8000_0003; a fourth read -> 0x0000_0000, FIFOCNT=0.
//  4. Push 9 entries with FIFO_DEPTH=8 -> FIFOCNT=8, FLAGS[2]=1; with
//     IRQ_EN=0x4, IRQ=1 one cycle later; write 0x04=0x4 -> flag and IRQ clear.
//  5. Hold FaultInt=1 while writing 0x04=0x1 -> FLAGS[0] stays 1; drop FaultInt,
//     write again -> FLAGS[0]=0.
//  6. Full FIFO, pop and IntValid in the same cycle -> count stays 8, ovf=0,
//     new entry read last. With APB_MCU_PSLVERR_EN: write 0x00 -> PSLVERR=1 in
//     the access phase.

Source files
------------

// File: rtl/apb_mcu_maint_regs.sv
// rtl/apb_mcu_maint_regs.sv - APB3 slave exposing MCU2IPU core status, sticky flags and an interrupt FIFO
// Optional APB_MCU_PSLVERR_EN adds a registered PSLVERR output.
module apb_mcu_maint_regs #(
  parameter int NUM_CORES  = 4,
  parameter int INT_INFO_W = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_W-1:0]     PADDR,
  input  logic [31:0]           PWDATA,
  output logic [31:0]           PRDATA,
  output logic                  PREADY,
  input  logic [NUM_CORES-1:0]  MCU2IPU_CoreRunning,
  input  logic [NUM_CORES-1:0]  MCU2IPU_CoreOnline,
  input  logic                  MCU2IPU_FaultInt,
  input  logic                  MCU2IPU_NMI,
  input  logic                  MCU2IPU_IntValid,
  input  logic [INT_INFO_W-1:0] MCU2IPU_IntInfo,
  output logic                  IRQ
`ifdef APB_MCU_PSLVERR_EN
  ,
  output logic                  PSLVERR
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  localparam logic [2:0] A_STATUS  = 3'd0;
  localparam logic [2:0] A_FLAGS   = 3'd1;
  localparam logic [2:0] A_INTPOP  = 3'd2;
  localparam logic [2:0] A_FIFOCNT = 3'd3;
  localparam logic [2:0] A_IRQ_EN  = 3'd4;

  logic                  setup;
  logic                  access;
  logic [2:0]            reg_sel;

  logic [INT_INFO_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;

  logic                  fault_flag;
  logic                  nmi_flag;
  logic                  ovf_flag;
  logic [3:0]            irq_en;
  logic                  pop_armed;

  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  wr_flags;
  logic                  wr_irq_en;
  logic                  pop_do;
  logic                  push_do;
  logic                  ovf_set;
  logic [31:0]           rdata;
  logic                  unused_ok;

  assign setup   = PSEL & ~PENABLE;
  assign access  = PSEL & PENABLE;
  assign reg_sel = PADDR[4:2];
  assign PREADY  = 1'b1;

  assign unused_ok = ^{PADDR[ADDR_W-1:5], PADDR[1:0], PWDATA[31:4]};

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);
  assign wr_flags   = access & PWRITE & (reg_sel == A_FLAGS);
  assign wr_irq_en  = access & PWRITE & (reg_sel == A_IRQ_EN);

  // A pop is only honoured if the FIFO was non-empty when the read was set up.
  assign pop_do  = access & ~PWRITE & (reg_sel == A_INTPOP) & pop_armed & ~fifo_empty;
  assign push_do = MCU2IPU_IntValid & (~fifo_full | pop_do);
  assign ovf_set = MCU2IPU_IntValid & ~push_do;

  always_comb begin
    rdata = '0;
    case (reg_sel)
      A_STATUS: begin
        rdata[NUM_CORES-1:0]    = MCU2IPU_CoreRunning;
        rdata[16 +: NUM_CORES]  = MCU2IPU_CoreOnline;
      end
      A_FLAGS:   rdata[2:0] = {ovf_flag, nmi_flag, fault_flag};
      A_INTPOP: begin
        if (!fifo_empty) begin
          rdata[31]               = 1'b1;
          rdata[INT_INFO_W-1:0]   = mem[rd_ptr];
        end
      end
      A_FIFOCNT: rdata[CNT_W-1:0] = count;
      A_IRQ_EN:  rdata[3:0]       = irq_en;
      default:   rdata = '0;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      PRDATA     <= '0;
      IRQ        <= 1'b0;
      fault_flag <= 1'b0;
      nmi_flag   <= 1'b0;
      ovf_flag   <= 1'b0;
      irq_en     <= '0;
      pop_armed  <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      if (setup & ~PWRITE) begin
        PRDATA <= rdata;
      end
      pop_armed <= setup & ~PWRITE & (reg_sel == A_INTPOP) & ~fifo_empty;

      // Set terms are OR-ed last so a concurrent source wins over a W1C clear.
      fault_flag <= (fault_flag & ~(wr_flags & PWDATA[0])) | MCU2IPU_FaultInt;
      nmi_flag   <= (nmi_flag   & ~(wr_flags & PWDATA[1])) | MCU2IPU_NMI;
      ovf_flag   <= (ovf_flag   & ~(wr_flags & PWDATA[2])) | ovf_set;

      if (wr_irq_en) begin
        irq_en <= PWDATA[3:0];
      end

      if (push_do) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_do) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_do, pop_do})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      IRQ <= (|(irq_en[2:0] & {ovf_flag, nmi_flag, fault_flag})) | (irq_en[3] & ~fifo_empty);
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESET && push_do) begin
      mem[wr_ptr] <= MCU2IPU_IntInfo;
    end
  end

`ifdef APB_MCU_PSLVERR_EN
  logic err_cond;

  always_comb begin
    err_cond = 1'b0;
    case (reg_sel)
      A_STATUS, A_FIFOCNT: err_cond = PWRITE;
      A_INTPOP:            err_cond = PWRITE | fifo_empty;
      A_FLAGS, A_IRQ_EN:   err_cond = 1'b0;
      default:             err_cond = 1'b1;
    endcase
  end

  // Registered at the setup edge, so it is high for exactly the access cycle.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      PSLVERR <= 1'b0;
    end else begin
      PSLVERR <= setup & err_cond;
    end
  end
`endif

endmodule

// File: tb/tb_apb_mcu_maint_regs.sv
// tb/tb_apb_mcu_maint_regs.sv - scoreboard bench for apb_mcu_maint_regs
module tb_apb_mcu_maint_regs;

  logic        PCLK;
  logic        PRESET;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [15:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic [3:0]  MCU2IPU_CoreRunning;
  logic [3:0]  MCU2IPU_CoreOnline;
  logic        MCU2IPU_FaultInt;
  logic        MCU2IPU_NMI;
  logic        MCU2IPU_IntValid;
  logic [3:0]  MCU2IPU_IntInfo;
  logic        IRQ;
`ifdef APB_MCU_PSLVERR_EN
  logic        PSLVERR;
  logic        err_probe;
`endif
  logic        irq_probe;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  apb_mcu_maint_regs #(
    .NUM_CORES(4), .INT_INFO_W(4), .FIFO_DEPTH(8), .ADDR_W(16)
  ) dut (
    .PCLK(PCLK),
    .PRESET(PRESET),
    .PSEL(PSEL),
    .PENABLE(PENABLE),
    .PWRITE(PWRITE),
    .PADDR(PADDR),
    .PWDATA(PWDATA),
    .PRDATA(PRDATA),
    .PREADY(PREADY),
    .MCU2IPU_CoreRunning(MCU2IPU_CoreRunning),
    .MCU2IPU_CoreOnline(MCU2IPU_CoreOnline),
    .MCU2IPU_FaultInt(MCU2IPU_FaultInt),
    .MCU2IPU_NMI(MCU2IPU_NMI),
    .MCU2IPU_IntValid(MCU2IPU_IntValid),
    .MCU2IPU_IntInfo(MCU2IPU_IntInfo),
    .IRQ(IRQ)
`ifdef APB_MCU_PSLVERR_EN
    ,
    .PSLVERR(PSLVERR)
`endif
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  task automatic sb_push(input int kind, input logic [31:0] exp, input string nm);
    exp_t e;
    e.kind = kind;
    e.exp  = exp;
    e.name = nm;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input int kind, input logic [31:0] act);
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_sample kind=%0d: actual=0x%08h required=none", kind, act);
    end else begin
      e = sb_q.pop_front();
      if (e.kind != kind || act !== e.exp) begin
        errors++;
        $display("FAIL %s: actual=0x%08h required=0x%08h (kind %0d, expected kind %0d)",
                 e.name, act, e.exp, kind, e.kind);
      end
    end
  endtask

  // Monitor: read data in every read access phase, IRQ/PSLVERR on probe strobes.
  always @(negedge PCLK) begin
    if (PSEL && PENABLE && !PWRITE && PREADY) sb_check(0, PRDATA);
    if (irq_probe) sb_check(1, {31'b0, IRQ});
`ifdef APB_MCU_PSLVERR_EN
    if (err_probe) sb_check(2, {31'b0, PSLVERR});
`endif
  end

  task automatic apb_read(input logic [15:0] a, input logic [31:0] exp, input string nm,
                          input bit push_en = 1'b0, input logic [3:0] push_val = 4'h0);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    sb_push(0, exp, nm);
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    MCU2IPU_IntValid = push_en;
    MCU2IPU_IntInfo  = push_val;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; MCU2IPU_IntValid = 1'b0;
  endtask

  task automatic apb_write(input logic [15:0] a, input logic [31:0] d);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

`ifdef APB_MCU_PSLVERR_EN
  task automatic apb_write_err(input logic [15:0] a, input logic [31:0] d,
                               input logic exp_err, input string nm);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    sb_push(2, {31'b0, exp_err}, nm);
    @(posedge PCLK); #1;
    PENABLE = 1'b1; err_probe = 1'b1;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; err_probe = 1'b0;
  endtask
`endif

  task automatic probe_irq(input logic exp, input string nm);
    sb_push(1, {31'b0, exp}, nm);
    @(posedge PCLK); #1;
    irq_probe = 1'b1;
    @(posedge PCLK); #1;
    irq_probe = 1'b0;
  endtask

  task automatic push_int(input logic [3:0] v);
    @(posedge PCLK); #1;
    MCU2IPU_IntValid = 1'b1; MCU2IPU_IntInfo = v;
    @(posedge PCLK); #1;
    MCU2IPU_IntValid = 1'b0;
  endtask

  task automatic pulse_fault();
    @(posedge PCLK); #1; MCU2IPU_FaultInt = 1'b1;
    @(posedge PCLK); #1; MCU2IPU_FaultInt = 1'b0;
  endtask

  localparam logic [31:0] exp_pop6 [8] = '{32'h8000_0002, 32'h8000_0003, 32'h8000_0004,
                                           32'h8000_0005, 32'h8000_0006, 32'h8000_0007,
                                           32'h8000_0008, 32'h8000_000A};

  initial begin
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    MCU2IPU_CoreRunning = '0; MCU2IPU_CoreOnline = '0; MCU2IPU_FaultInt = 1'b0;
    MCU2IPU_NMI = 1'b0; MCU2IPU_IntValid = 1'b0; MCU2IPU_IntInfo = '0;
    irq_probe = 1'b0;
`ifdef APB_MCU_PSLVERR_EN
    err_probe = 1'b0;
`endif
    repeat (3) @(posedge PCLK);
    #1 PRESET = 1'b0;

    apb_read(16'h04, 32'h0, "rst_flags");
    apb_read(16'h0C, 32'h0, "rst_fifocnt");
    apb_read(16'h10, 32'h0, "rst_irq_en");
    probe_irq(1'b0, "rst_irq");

    MCU2IPU_CoreRunning = 4'b1010; MCU2IPU_CoreOnline = 4'b1111;
    apb_read(16'h00, 32'h000F_000A, "status_a");
    MCU2IPU_CoreRunning = 4'b0101; MCU2IPU_CoreOnline = 4'b0011;
    apb_read(16'h00, 32'h0003_0005, "status_b");
    apb_read(16'h14, 32'h0, "unmapped_14");
    apb_read(16'h1C, 32'h0, "unmapped_1c");

    push_int(4'h1); push_int(4'h2); push_int(4'h3);
    apb_read(16'h0C, 32'h3, "cnt_3");
    apb_read(16'h08, 32'h8000_0001, "pop_1");
    apb_read(16'h08, 32'h8000_0002, "pop_2");
    apb_read(16'h08, 32'h8000_0003, "pop_3");
    apb_read(16'h08, 32'h0, "pop_empty");
    apb_read(16'h0C, 32'h0, "cnt_after_pops");

    MCU2IPU_FaultInt = 1'b1;
    apb_write(16'h04, 32'h1);
    apb_read(16'h04, 32'h1, "fault_set_wins");
    MCU2IPU_FaultInt = 1'b0;
    apb_write(16'h04, 32'h1);
    apb_read(16'h04, 32'h0, "fault_cleared");

    @(posedge PCLK); #1 MCU2IPU_NMI = 1'b1;
    @(posedge PCLK); #1 MCU2IPU_NMI = 1'b0;
    apb_read(16'h04, 32'h2, "nmi_sticky");
    apb_write(16'h10, 32'h2);
    probe_irq(1'b1, "irq_nmi");
    apb_read(16'h10, 32'h2, "irq_en_rb");
    apb_write(16'h04, 32'h1);
    apb_read(16'h04, 32'h2, "nmi_wrong_bit");
    apb_write(16'h04, 32'h2);
    probe_irq(1'b0, "irq_nmi_clr");
    apb_read(16'h04, 32'h0, "nmi_cleared");

    apb_write(16'h10, 32'h4);
    for (int i = 1; i <= 9; i++) push_int(4'(i));
    apb_read(16'h0C, 32'h8, "cnt_full");
    apb_read(16'h04, 32'h4, "ovf_set");
    probe_irq(1'b1, "irq_ovf");
    apb_write(16'h04, 32'h4);
    probe_irq(1'b0, "irq_ovf_clr");
    apb_read(16'h04, 32'h0, "ovf_cleared");
    apb_write(16'h0C, 32'h0);
    apb_read(16'h0C, 32'h8, "ro_write_ignored");
`ifdef APB_MCU_PSLVERR_EN
    apb_write_err(16'h00, 32'h0, 1'b1, "pslverr_ro");
    apb_write_err(16'h10, 32'h4, 1'b0, "pslverr_ok");
`endif

    apb_read(16'h08, 32'h8000_0001, "pop_push_full", 1'b1, 4'hA);
    apb_read(16'h0C, 32'h8, "cnt_pop_push_full");
    apb_read(16'h04, 32'h0, "no_ovf_pop_push");
    for (int i = 0; i < 8; i++) apb_read(16'h08, exp_pop6[i], "drain");
    apb_read(16'h08, 32'h0, "drain_empty");
    apb_read(16'h0C, 32'h0, "drain_cnt");

    apb_write(16'h10, 32'h8);
    push_int(4'h1); push_int(4'h2); push_int(4'h3);
    pulse_fault();
    probe_irq(1'b1, "irq_nonempty");
    apb_read(16'h0C, 32'h3, "cnt_pre_reset");

    @(posedge PCLK); #1;
    PRESET = 1'b1; PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 16'h08;
    sb_push(0, 32'h0, "reset_mid_read");
    @(posedge PCLK); #1;
    PRESET = 1'b0; PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    apb_read(16'h0C, 32'h0, "reset_cnt");
    apb_read(16'h04, 32'h0, "reset_flags");
    apb_read(16'h10, 32'h0, "reset_irq_en");
    probe_irq(1'b0, "reset_irq");

    repeat (3) @(posedge PCLK);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: actual=%0d pending required=0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
